// File: rtl/filt_cicd_pkg.sv
// filt_cicd_pkg: shared clog2 helper, default output width and default-width signed sample type for the CIC decimator
package filt_cicd_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int oup_width_dflt = 16 + 3 * clog2(8 * 1);
  typedef logic signed [oup_width_dflt-1:0] sample_t;
endpackage

// File: rtl/filt_cicd_comb.sv
// filt_cicd_comb: one comb stage y <= x - x(m decimated samples ago); ports clk (decimated clock), rst_n (async active-low), x (stage input), y (registered stage output)
module filt_cicd_comb
  import filt_cicd_pkg::*;
#(
  parameter int w = oup_width_dflt,
  parameter int m = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [w-1:0] x,
  output logic signed [w-1:0] y
);
  logic signed [w-1:0] dly [m];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y <= '0;
      for (int i = 0; i < m; i++) dly[i] <= '0;
    end else begin
      y <= x - dly[m-1];
      dly[0] <= x;
      for (int i = 1; i < m; i++) dly[i] <= dly[i-1];
    end
endmodule

// File: rtl/filt_cicd.sv
// filt_cicd: CIC decimator (N integrators at i_clk, decimate by R, N combs on internal w_sclk); ports i_clk, i_rst_an (async active-low), i_ena (input-rate enable), i_data (signed sample), o_data (full-precision decimated output)
module filt_cicd
  import filt_cicd_pkg::*;
#(
  parameter int gp_decimation_factor = 8,
  parameter int gp_order             = 3,
  parameter int gp_diff_delay        = 1,
  parameter int gp_phase             = 0,
  parameter int gp_inp_width         = 16,
  parameter int gp_oup_width         = gp_inp_width + gp_order * clog2(gp_decimation_factor * gp_diff_delay)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_an,
  input  logic                           i_ena,
  input  logic signed [gp_inp_width-1:0] i_data,
  output logic signed [gp_oup_width-1:0] o_data
);
  localparam int r  = gp_decimation_factor;
  localparam int cw = clog2(r);
  localparam int w  = gp_oup_width;
  logic [cw-1:0] cnt, cnt_nxt;
  logic w_sclk;
  logic signed [w-1:0] integ [gp_order];
  logic signed [w-1:0] dec;
  logic signed [w-1:0] stg [gp_order+1];
  assign cnt_nxt = (cnt == cw'(r - 1)) ? '0 : cnt + cw'(1);
  // w_sclk is registered from the next count so its rising edge lands on the wrap to 0
  always_ff @(posedge i_clk or negedge i_rst_an)
    if (!i_rst_an) begin
      cnt <= cw'(gp_phase);
      w_sclk <= 1'(gp_phase < r / 2);
      for (int i = 0; i < gp_order; i++) integ[i] <= '0;
    end else if (i_ena) begin
      cnt <= cnt_nxt;
      w_sclk <= cnt_nxt < cw'(r / 2);
      integ[0] <= integ[0] + w'(i_data);
      for (int i = 1; i < gp_order; i++) integ[i] <= integ[i] + integ[i-1];
    end
  always_ff @(posedge w_sclk or negedge i_rst_an)
    if (!i_rst_an) dec <= '0;
    else dec <= integ[gp_order-1];
  assign stg[0] = dec;
  for (genvar k = 0; k < gp_order; k++) begin : g_comb
    filt_cicd_comb #(.w(w), .m(gp_diff_delay)) u_comb (
      .clk  (w_sclk),
      .rst_n(i_rst_an),
      .x    (stg[k]),
      .y    (stg[k+1])
    );
  end
  assign o_data = stg[gp_order];
endmodule

// File: tb/tb_filt_cicd.sv
// tb_filt_cicd: self-checking bench for filt_cicd at defaults plus two swept parameter sets driven by the same stimulus
module tb_filt_cicd;
  logic i_clk = 1'b0;
  logic i_rst_an = 1'b1;
  logic i_ena = 1'b0;
  logic signed [15:0] i_data = '0;
  logic signed [24:0] o0;
  logic signed [18:0] o1;
  logic signed [40:0] o2;
  always #5 i_clk = ~i_clk;
  filt_cicd u0 (.i_clk(i_clk), .i_rst_an(i_rst_an), .i_ena(i_ena), .i_data(i_data), .o_data(o0));
  filt_cicd #(.gp_decimation_factor(4), .gp_order(1), .gp_diff_delay(2), .gp_phase(3)) u1 (
    .i_clk(i_clk), .i_rst_an(i_rst_an), .i_ena(i_ena), .i_data(i_data), .o_data(o1));
  filt_cicd #(.gp_decimation_factor(16), .gp_order(5), .gp_diff_delay(2), .gp_phase(3)) u2 (
    .i_clk(i_clk), .i_rst_an(i_rst_an), .i_ena(i_ena), .i_data(i_data), .o_data(o2));
  typedef struct {
    logic signed [15:0] data;
    longint e0, e1, e2;
  } vec_t;
  int pr[3] = '{8, 4, 16};
  int pn[3] = '{3, 1, 5};
  int pm[3] = '{1, 2, 2};
  int pp[3] = '{0, 3, 3};
  int pw[3] = '{25, 19, 41};
  longint xs[8192];
  int nx;
  longint dq[3][4096];
  int cap[3];
  int checks = 0;
  int failures = 0;
  function automatic longint binom(input longint a, input int b);
    longint c = 1;
    for (int i = 1; i <= b; i++) c = c * (a - b + i) / i;
    return c;
  endfunction
  function automatic longint wrapw(input longint v, input int w);
    return (w >= 64) ? v : ((v <<< (64 - w)) >>> (64 - w));
  endfunction
  // n-th output of an N-deep integrator cascade: sum x[j]*C(n-j+N-1, N-1)
  function automatic longint integ_out(input int n, input int nn, input int w);
    longint s = 0;
    if (n < 0) return 0;
    for (int j = 0; j <= n; j++) s += xs[j] * binom(longint'(n - j + nn - 1), nn - 1);
    return wrapw(s, w);
  endfunction
  // N-fold M-difference of the decimated sequence, delayed by the N comb registers
  function automatic longint exp_out(input int mi);
    longint s = 0;
    int i;
    if (cap[mi] == 0) return 0;
    i = cap[mi] - 1 - pn[mi];
    for (int k = 0; k <= pn[mi]; k++)
      if (i - k * pm[mi] >= 0)
        s += ((k % 2) ? -64'sd1 : 64'sd1) * binom(longint'(pn[mi]), k) * dq[mi][i - k * pm[mi]];
    return wrapw(s, pw[mi]);
  endfunction
  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("o0", o0, exp_out(0));
    chk("o1", o1, exp_out(1));
    chk("o2", o2, exp_out(2));
    chk("sclk0", longint'(u0.w_sclk), longint'(((pp[0] + nx) % pr[0]) < pr[0] / 2));
    chk("sclk1", longint'(u1.w_sclk), longint'(((pp[1] + nx) % pr[1]) < pr[1] / 2));
    chk("sclk2", longint'(u2.w_sclk), longint'(((pp[2] + nx) % pr[2]) < pr[2] / 2));
  endtask
  task automatic step(input logic ena, input logic signed [15:0] d);
    i_ena = ena;
    i_data = d;
    @(posedge i_clk);
    if (ena) begin
      xs[nx] = longint'(d);
      nx++;
      for (int mi = 0; mi < 3; mi++)
        if ((pp[mi] + nx) % pr[mi] == 0) begin
          dq[mi][cap[mi]] = integ_out(nx - pn[mi], pn[mi], pw[mi]);
          cap[mi]++;
        end
    end
    @(negedge i_clk);
    check_all();
  endtask
  task automatic do_reset();
    #2 i_rst_an = 1'b0;
    #1;
    nx = 0;
    cap = '{0, 0, 0};
    check_all();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_an = 1'b1;
  endtask
  initial begin
    vec_t tbl[4];
    longint s, tot;
    logic ps;
    tbl[0] = '{16'sd1, 64'sd512, 64'sd8, 64'sd33554432};
    tbl[1] = '{16'sd32767, 64'sd16776704, 64'sd262136, 64'sd1099478073344};
    tbl[2] = '{16'sh8000, -64'sd16777216, -64'sd262144, -64'sd1099511627776};
    tbl[3] = '{16'sd100, 64'sd51200, 64'sd800, 64'sd3355443200};
    do_reset();
    for (int v = 0; v < 4; v++) begin
      repeat (400) step(1'b1, tbl[v].data);
      chk("dc0", o0, tbl[v].e0);
      chk("dc1", o1, tbl[v].e1);
      chk("dc2", o2, tbl[v].e2);
    end
    repeat (37) step(1'b1, 16'sd100);
    do_reset();
    repeat (400) step(1'b1, 16'sd100);
    chk("rst_ramp0", o0, 64'sd51200);
    chk("rst_ramp2", o2, 64'sd3355443200);
    // 301-cycle spacing walks the impulse through every decimation phase;
    // each phase's decimated response carries R^(N-1)=64, all eight together 512
    do_reset();
    tot = 0;
    ps = u0.w_sclk;
    for (int p = 0; p < 8; p++) begin
      s = 0;
      for (int c = 0; c < 301; c++) begin
        step(1'b1, (c == 0) ? 16'sd1 : 16'sd0);
        if (u0.w_sclk && !ps) s += longint'(o0);
        ps = u0.w_sclk;
      end
      chk("imp_sum", s, 64'sd64);
      chk("imp_tail", o0, 64'sd0);
      tot += s;
    end
    chk("imp_total", tot, 64'sd512);
    do_reset();
    repeat (100) step(1'b1, 16'($urandom));
    repeat (20) step(1'b0, 16'($urandom));
    repeat (100) step(1'b1, 16'($urandom));
    do_reset();
    repeat (600) step($urandom_range(0, 7) != 0, 16'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
